// File: rtl/arm_pkg.sv
// arm_pkg: shared definitions for the register-file write side.
//   REG_AW     register address width
//   REG_PC     index of the program counter register (ordinary entry here)
//   DATA_W     datapath width
//   FLG_*      bit positions of N, Z, C, V inside a 4-bit flags word
//   wb_entry_t one pending write-back: destination, result, enables, flags
package arm_pkg;

    localparam int REG_AW = 4;
    localparam int REG_PC = 15;
    localparam int DATA_W = 32;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;        // destination register
        logic [DATA_W-1:0] data;      // result value
        logic              we;        // 0 = flags-only write
        logic              flags_en;  // update NZCV on retire
        logic [3:0]        flags;     // {N,Z,C,V}
    } wb_entry_t;

endpackage

// File: rtl/reg_write_if.sv
// reg_write_if: valid/ready write-back port from execute into the register file.
//   wb_valid    write request (producer)
//   wb_ready    queue can accept (register file)
//   wb_reg      destination register
//   wb_data     result value
//   wb_we       register write enable (0 = flags-only)
//   wb_flags_en update NZCV
//   wb_flags    {N,Z,C,V}
// Modports: master = producer (execute), slave = reg_write.
interface reg_write_if #(
    parameter int W = arm_pkg::DATA_W
);
    logic                      wb_valid;
    logic                      wb_ready;
    logic [arm_pkg::REG_AW-1:0] wb_reg;
    logic [W-1:0]              wb_data;
    logic                      wb_we;
    logic                      wb_flags_en;
    logic [3:0]                wb_flags;

    modport master (
        output wb_valid, wb_reg, wb_data, wb_we, wb_flags_en, wb_flags,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data, wb_we, wb_flags_en, wb_flags,
        output wb_ready
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: in-order queue of pending write-backs.
//   clk, rst_n  clock, asynchronous active-low reset (empties the queue)
//   push, pop   enqueue din / dequeue head (caller guarantees !full / !empty)
//   din, head   entry in, oldest entry out
//   count       number of occupied entries
//   full, empty occupancy flags
//   ent_ord     all entries in age order, index 0 = oldest
//   vld_ord     per-entry valid, same order as ent_ord
module wb_fifo
    import arm_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  wb_entry_t              din,
    output wb_entry_t              head,
    output logic [PW:0]            count,
    output logic                   full,
    output logic                   empty,
    output wb_entry_t [DEPTH-1:0]  ent_ord,
    output logic [DEPTH-1:0]       vld_ord
);

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // NOTE: storage is deliberately not reset; an entry is only ever read
    // while its valid bit (derived from the reset count) is set.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    // Pointer arithmetic wraps modulo DEPTH because DEPTH is a power of two.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ent_ord[k] = mem[rd_ptr + PW'(k)];
            vld_ord[k] = ((PW+1)'(k) < count);
        end
    end

endmodule

// File: rtl/reg_write.sv
// reg_write: architectural register file + NZCV flags, fed by a write queue.
//   clk, rst_n               clock, asynchronous active-low reset
//   wb                       write-back port (reg_write_if.slave)
//   r_reg_add_{1,2,s}        read addresses from the read stage
//   r_vld_{1,2,s}            address valid; opr_* is 0 when low
//   opr_{1,2,s}              read data, queued writes forwarded (newest wins)
//   flags                    retired NZCV
//   q_empty                  no pending writes
module reg_write
    import arm_pkg::*;
#(
    parameter int NREG  = 16,
    parameter int W     = DATA_W,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_write_if.slave        wb,
    input  logic [REG_AW-1:0] r_reg_add_1,
    input  logic [REG_AW-1:0] r_reg_add_2,
    input  logic [REG_AW-1:0] r_reg_add_s,
    input  logic              r_vld_1,
    input  logic              r_vld_2,
    input  logic              r_vld_s,
    output logic [W-1:0]      opr_1,
    output logic [W-1:0]      opr_2,
    output logic [W-1:0]      opr_s,
    output logic [3:0]        flags,
    output logic              q_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]          rf [NREG];
    wb_entry_t             din;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] ent_ord;
    logic [DEPTH-1:0]      vld_ord;
    logic [PW:0]           count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign din = '{rd: wb.wb_reg, data: wb.wb_data, we: wb.wb_we,
                   flags_en: wb.wb_flags_en, flags: wb.wb_flags};

    // Ready depends only on the registered count, never on wb_valid.
    assign wb.wb_ready = !full;
    assign push        = wb.wb_valid && wb.wb_ready;
    assign pop         = !empty;       // head retires every non-empty cycle
    assign q_empty     = empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .din     (din),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ent_ord (ent_ord),
        .vld_ord (vld_ord)
    );

    // NOTE: unlike the queue storage, the register file is architectural
    // state and must read as zero after reset, so every entry is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            flags <= '0;
        end else if (pop) begin
            if (head.we)       rf[head.rd] <= head.data;
            if (head.flags_en) flags       <= head.flags;
        end
    end

    // Read ports: rf value, overridden oldest-to-newest by matching queued
    // writes so the newest pending write wins. An invalid port is forced to 0
    // before its address is used, which keeps X addresses from propagating.
    logic [REG_AW-1:0] raddr [3];
    logic              rvld  [3];
    logic [W-1:0]      rdata [3];

    assign raddr[0] = r_reg_add_1;
    assign raddr[1] = r_reg_add_2;
    assign raddr[2] = r_reg_add_s;
    assign rvld[0]  = r_vld_1;
    assign rvld[1]  = r_vld_2;
    assign rvld[2]  = r_vld_s;

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first so no latch is inferred.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rdata[p] = '0;
            if (rvld[p]) begin
                rdata[p] = rf[raddr[p]];
                for (int k = 0; k < DEPTH; k++) begin
                    if (vld_ord[k] && ent_ord[k].we && (ent_ord[k].rd == raddr[p]))
                        rdata[p] = ent_ord[k].data;
                end
            end
        end
    end

    assign opr_1 = rdata[0];
    assign opr_2 = rdata[1];
    assign opr_s = rdata[2];

endmodule
